aes_regbank: RTL and testbench
==============================

# aes_regbank

Byte-wide register bank between the chip's pad ring and the AES datapath. It turns the 8-bit valid/wen/addr/wdata/rdata host bus into 128-bit key and plaintext operands, sequences one encryption via a start/done handshake, captures the ciphertext, and serves status, result and latency readback to the host.

## Interface

- TIMEOUT, 64: cycles allowed from core_start to core_done before abort (only with watchdog compiled in).
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- valid  in  1  bus transfer qualifier; one transfer per cycle it is high.
- wen  in  1  1 = write, 0 = read; meaningful only with valid.
- addr  in  8  byte address.
- wdata  in  8  write data.
- rdata  out  8  registered read data.
- core_key  out  128  key operand, big-endian (byte 0x00 = bits [127:120]).
- core_ptext  out  128  plaintext operand, same byte order.
- core_start  out  1  one-cycle start pulse to the core.
- core_done  in  1  one-cycle completion pulse from the core.
- core_ctext  in  128  ciphertext; valid in the cycle core_done is high.

## Operation

- Address map: 0x00–0x0F KEY (RW); 0x10–0x1F PTEXT (RW); 0x20–0x2F CTEXT (RO); 0x30 CTRL (WO: bit0 START, bit1 CLEAR); 0x31 STATUS (RO: bit0 BUSY, bit1 DONE, bit2 ERR, bit3 TMO); 0x32 CYCLES (RO). Unmapped reads return 0x00; unmapped writes and writes to RO addresses are ignored.
- States: IDLE, START, RUN.
  - IDLE: START write → START.
  - START: core_start = 1 for exactly this cycle; CYCLES cleared; → RUN.
  - RUN: CYCLES increments each cycle, saturating at 0xFF. core_done → capture core_ctext into CTEXT, set DONE, → IDLE.
- BUSY = 1 in START and RUN.
- While BUSY: KEY/PTEXT writes are dropped and set ERR; a START write sets ERR and is otherwise ignored.
- CLEAR (allowed in any state): clears DONE, ERR, TMO and CTEXT. It does not change state. START and CLEAR written together in IDLE: flags clear and the run starts.
- core_done outside RUN is ignored.
- DONE, ERR and TMO are sticky until CLEAR or reset.
- Reset value of every register and output is 0: KEY, PTEXT, CTEXT, CYCLES, flags, rdata, core_start. State resets to IDLE.
- Reset mid-run: the block returns to IDLE with no capture. A late core_done is ignored.

## Timing

- Write: takes effect at the clock edge where valid && wen is high.
- Read: rdata is loaded at the edge where valid && !wen is high, so data is visible the following cycle. rdata holds its value when there is no read.
- A read returns the pre-edge register value. A STATUS read in the same cycle as core_done returns BUSY = 1.
- START written at edge N gives core_start high between edges N+1 and N+2. The first RUN cycle starts at edge N+2.
- core_done sampled at edge M: CTEXT and DONE update at M, and a read issued at edge M+1 sees them.
- CYCLES = number of RUN cycles up to and including the core_done cycle.

## Configuration

- AES_REGBANK_WATCHDOG_EN defined:
  - A RUN counter aborts the run when TIMEOUT cycles pass without core_done.
  - On abort: set TMO, leave CTEXT unchanged, leave DONE clear, → IDLE.
  - core_done arriving after the abort is ignored.
- Not defined: RUN waits indefinitely for core_done, TMO reads 0, and TIMEOUT is unused.

## Structure

- Shared package aes_regbank_pkg holds:
  - address constants: KEY_BASE, PTEXT_BASE, CTEXT_BASE, CTRL_ADDR, STATUS_ADDR, CYCLES_ADDR;
  - STATUS and CTRL bit indices;
  - the state enum.
- One sub-module, aes_regbank_rdmux: a combinational read-data selector from addr and the register contents. The FSM, the byte-lane writes and the capture logic stay in the top module.

## Test plan

- FIPS-197 C.1 case:
  - Stimulus: write KEY 0x00..0x0F = 00 01 … 0F and PTEXT = 00 11 22 … FF; write CTRL = 0x01. A behavioural core model asserts done 10 cycles after core_start.
  - Required: core_start pulses once; STATUS reads 0x01 while running, then 0x02; CTEXT 0x20..0x2F reads 69 C4 E0 D8 … C5 5A; CYCLES reads 0x0A.
- Writing KEY byte 0x05 = 0xAA while BUSY → KEY unchanged and STATUS ERR set. A following CLEAR → STATUS = 0x00 once idle.
- START written twice back-to-back → exactly one core_start pulse and ERR set.
- Reset asserted in RUN, then core_done pulsed → all outputs 0, STATUS = 0x00, CTEXT = 0.
- Reads of unmapped addresses 0x40 and 0xFF → 0x00. Writes to 0x20 → CTEXT unchanged.
- With AES_REGBANK_WATCHDOG_EN and TIMEOUT = 64, core never answers → STATUS = 0x08 after 64 RUN cycles and a new START is accepted. Without the macro → BUSY stays 1 for 1000 cycles.

Source files
------------

// File: rtl/aes_regbank_pkg.sv
// Shared address map, register bit positions, FSM encoding and byte-lane helpers
// for the aes_regbank host register bank.
package aes_regbank_pkg;

  localparam logic [7:0] KEY_BASE    = 8'h00;
  localparam logic [7:0] PTEXT_BASE  = 8'h10;
  localparam logic [7:0] CTEXT_BASE  = 8'h20;
  localparam logic [7:0] CTRL_ADDR   = 8'h30;
  localparam logic [7:0] STATUS_ADDR = 8'h31;
  localparam logic [7:0] CYCLES_ADDR = 8'h32;

  localparam int CTRL_START = 0;
  localparam int CTRL_CLEAR = 1;

  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_ERR  = 2;
  localparam int ST_TMO  = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  // True when addr falls in the 16-byte window starting at base.
  function automatic logic in_block(input logic [7:0] a, input logic [7:0] base);
    return (a & 8'hF0) == base;
  endfunction

  // Operands are big-endian: byte 0 of a window lives in bits [127:120].
  function automatic int lane_lsb(input logic [3:0] idx);
    return 8 * (15 - int'(idx));
  endfunction

endpackage

// File: rtl/aes_regbank_rdmux.sv
// Combinational read-data selector: maps a byte address onto the register contents.
// Unmapped and write-only addresses read as zero.
module aes_regbank_rdmux
  import aes_regbank_pkg::*;
(
  input  logic [7:0]   addr,
  input  logic [127:0] key,
  input  logic [127:0] ptext,
  input  logic [127:0] ctext,
  input  logic [7:0]   status,
  input  logic [7:0]   cycles,
  output logic [7:0]   data
);

  always_comb begin
    data = 8'h00;
    if (in_block(addr, KEY_BASE)) begin
      data = key[lane_lsb(addr[3:0]) +: 8];
    end else if (in_block(addr, PTEXT_BASE)) begin
      data = ptext[lane_lsb(addr[3:0]) +: 8];
    end else if (in_block(addr, CTEXT_BASE)) begin
      data = ctext[lane_lsb(addr[3:0]) +: 8];
    end else if (addr == STATUS_ADDR) begin
      data = status;
    end else if (addr == CYCLES_ADDR) begin
      data = cycles;
    end
  end

endmodule

// File: rtl/aes_regbank.sv
// Host byte-bus register bank feeding the AES core: operands, start/done sequencing,
// ciphertext capture and status/latency readback. Watchdog abort: AES_REGBANK_WATCHDOG_EN.
module aes_regbank
  import aes_regbank_pkg::*;
`ifdef AES_REGBANK_WATCHDOG_EN
  #(
    parameter int TIMEOUT = 64
  )
`endif
(
  input  logic         clk,
  input  logic         reset,
  input  logic         valid,
  input  logic         wen,
  input  logic [7:0]   addr,
  input  logic [7:0]   wdata,
  output logic [7:0]   rdata,
  output logic [127:0] core_key,
  output logic [127:0] core_ptext,
  output logic         core_start,
  input  logic         core_done,
  input  logic [127:0] core_ctext
);

  state_t       state;
  state_t       state_nxt;
  logic         start_pend;
  logic [127:0] key_q;
  logic [127:0] ptext_q;
  logic [127:0] ctext_q;
  logic         done_q;
  logic         err_q;
  logic         tmo_q;
  logic [7:0]   cycles_q;
  logic [7:0]   status;
  logic [7:0]   rd_dat;

  logic wr;
  logic rd;
  logic busy;
  logic locked;
  logic wr_key;
  logic wr_ptext;
  logic wr_ctrl;
  logic start_req;
  logic clear_req;
  logic capture;
  logic abort;

  assign wr        = valid && wen;
  assign rd        = valid && !wen;
  assign busy      = (state != S_IDLE);
  // An accepted START that has not yet issued already owns the operands.
  assign locked    = busy || start_pend;
  assign wr_key    = wr && in_block(addr, KEY_BASE);
  assign wr_ptext  = wr && in_block(addr, PTEXT_BASE);
  assign wr_ctrl   = wr && (addr == CTRL_ADDR);
  assign start_req = wr_ctrl && wdata[CTRL_START];
  assign clear_req = wr_ctrl && wdata[CTRL_CLEAR];
  assign capture   = (state == S_RUN) && core_done;

  assign status     = {4'b0000, tmo_q, err_q, done_q, busy};
  assign core_key   = key_q;
  assign core_ptext = ptext_q;

`ifdef AES_REGBANK_WATCHDOG_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);
  logic [15:0] wd_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if (state == S_START) begin
      wd_cnt <= '0;
    end else if (state == S_RUN) begin
      wd_cnt <= wd_cnt + 16'd1;
    end
  end

  // Fires on the last permitted RUN cycle when the core is still silent.
  assign abort = (state == S_RUN) && !core_done && (wd_cnt == WD_LAST);
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    core_start = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start_pend) begin
          state_nxt = S_START;
        end
      end
      S_START: begin
        core_start = 1'b1;
        state_nxt  = S_RUN;
      end
      S_RUN: begin
        if (capture || abort) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // One-cycle gap between the START write and the start pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      start_pend <= 1'b0;
    end else begin
      start_pend <= start_req && !locked;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      key_q   <= '0;
      ptext_q <= '0;
    end else begin
      if (wr_key && !locked) begin
        key_q[lane_lsb(addr[3:0]) +: 8] <= wdata;
      end
      if (wr_ptext && !locked) begin
        ptext_q[lane_lsb(addr[3:0]) +: 8] <= wdata;
      end
    end
  end

  // Later assignments win: a capture or abort in the same cycle as CLEAR survives it.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctext_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      if (clear_req) begin
        ctext_q <= '0;
        done_q  <= 1'b0;
        err_q   <= 1'b0;
        tmo_q   <= 1'b0;
      end
      if ((wr_key || wr_ptext || start_req) && locked) begin
        err_q <= 1'b1;
      end
      if (capture) begin
        ctext_q <= core_ctext;
        done_q  <= 1'b1;
      end
      if (abort) begin
        tmo_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycles_q <= '0;
    end else if (state == S_START) begin
      cycles_q <= '0;
    end else if ((state == S_RUN) && (cycles_q != 8'hFF)) begin
      cycles_q <= cycles_q + 8'd1;
    end
  end

  aes_regbank_rdmux u_rdmux (
    .addr   (addr),
    .key    (key_q),
    .ptext  (ptext_q),
    .ctext  (ctext_q),
    .status (status),
    .cycles (cycles_q),
    .data   (rd_dat)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= 8'h00;
    end else if (rd) begin
      rdata <= rd_dat;
    end
  end

endmodule

// File: tb/tb_aes_regbank.sv
// Scoreboarded bench for aes_regbank: bus reads push expectations from a byte-array model,
// a monitor pops and compares rdata; a behavioural core answers core_start after a set latency.
module tb_aes_regbank;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         valid = 1'b0;
  logic         wen = 1'b0;
  logic [7:0]   addr = 8'h00;
  logic [7:0]   wdata = 8'h00;
  logic [7:0]   rdata;
  logic [127:0] core_key;
  logic [127:0] core_ptext;
  logic         core_start;
  logic         core_done = 1'b0;
  logic [127:0] core_ctext = '0;

  aes_regbank dut (
    .clk        (clk),
    .reset      (reset),
    .valid      (valid),
    .wen        (wen),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .core_key   (core_key),
    .core_ptext (core_ptext),
    .core_start (core_start),
    .core_done  (core_done),
    .core_ctext (core_ctext)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int start_cnt = 0;
  int lat = 0;
  bit rd_seen = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
  } rd_exp_t;
  rd_exp_t rdq[$];

  // Reference model: plain byte arrays and flags.
  logic [7:0] key_m [16];
  logic [7:0] pt_m  [16];
  logic [7:0] ct_m  [16];
  logic       done_m, err_m, tmo_m, busy_m;
  logic [7:0] cyc_m;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [127:0] pack(input logic [7:0] b [16]);
    logic [127:0] r = '0;
    for (int i = 0; i < 16; i++) r = {r[119:0], b[i]};
    return r;
  endfunction

  function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] p);
    if (k == FIPS_KEY && p == FIPS_PT) return FIPS_CT;
    return k ^ {p[63:0], p[127:64]} ^ 128'h5a5a_0f0f_c3c3_9696_a5a5_f0f0_3c3c_6969;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      key_m[i] = 8'h00; pt_m[i] = 8'h00; ct_m[i] = 8'h00;
    end
    done_m = 0; err_m = 0; tmo_m = 0; busy_m = 0; cyc_m = 8'h00;
  endfunction

  function automatic logic [7:0] model_read(input logic [7:0] a);
    if (a < 8'h10) return key_m[a[3:0]];
    if (a < 8'h20) return pt_m[a[3:0]];
    if (a < 8'h30) return ct_m[a[3:0]];
    if (a == 8'h31) return {4'h0, tmo_m, err_m, done_m, busy_m};
    if (a == 8'h32) return cyc_m;
    return 8'h00;
  endfunction

  function automatic void model_write(input logic [7:0] a, input logic [7:0] d);
    if (a < 8'h20) begin
      if (busy_m) err_m = 1;
      else if (a < 8'h10) key_m[a[3:0]] = d;
      else pt_m[a[3:0]] = d;
    end else if (a == 8'h30) begin
      if (d[1]) begin
        done_m = 0; err_m = 0; tmo_m = 0;
        for (int i = 0; i < 16; i++) ct_m[i] = 8'h00;
      end
      if (d[0]) begin
        if (busy_m) err_m = 1;
        else busy_m = 1;
      end
    end
  endfunction

  task automatic op_wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    valid = 1; wen = 1; addr = a; wdata = d;
    model_write(a, d);
  endtask

  task automatic op_rd(input logic [7:0] a);
    rd_exp_t e;
    @(negedge clk);
    valid = 1; wen = 0; addr = a; wdata = 8'h00;
    e.a = a; e.d = model_read(a);
    rdq.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid = 0; wen = 0;
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    valid = 0; wen = 0; reset = 1;
    repeat (n) @(negedge clk);
    reset = 0;
    model_reset();
  endtask

  task automatic wait_done(input string name);
    bit seen = 0;
    logic [127:0] ct;
    @(negedge clk);
    valid = 0; wen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(posedge clk);
      if (core_done) seen = 1;
    end
    n_checks++;
    if (seen) n_pass++;
    else $display("FAIL %s: core_done not seen within 400 cycles", name);
    if (seen) begin
      ct = core_fn(pack(key_m), pack(pt_m));
      for (int i = 0; i < 16; i++) ct_m[i] = ct[127-8*i -: 8];
      done_m = 1; busy_m = 0; cyc_m = 8'(lat);
    end
  endtask

  // Behavioural core: answers lat cycles after core_start; lat == 0 never answers.
  initial begin : core_model
    int l;
    logic [127:0] r;
    forever begin
      @(negedge clk);
      if (core_start && lat != 0) begin
        l = lat;
        r = core_fn(core_key, core_ptext);
        repeat (l) @(negedge clk);
        core_done = 1; core_ctext = r;
        @(negedge clk);
        core_done = 0; core_ctext = '0;
      end
    end
  end

  always @(posedge clk) begin
    if (core_start === 1'b1) start_cnt++;
    rd_seen = valid && !wen && !reset;
  end

  initial begin : monitor
    rd_exp_t e;
    forever begin
      @(negedge clk);
      if (rd_seen) begin
        if (rdq.size() == 0) begin
          n_checks++;
          $display("FAIL rdq_underflow: read seen, got %0h required an expectation", rdata);
        end else begin
          e = rdq.pop_front();
          check($sformatf("read_%02h", e.a), {120'd0, rdata}, {120'd0, e.d});
        end
      end
    end
  end

  initial begin : bound
    #2000000;
    $display("FAIL time_bound: simulation did not finish, got timeout required $finish");
    $fatal(1, "time bound exceeded");
  end

  initial begin : stim
    int s0;
    logic [7:0] a;
    model_reset();
    do_reset(3);

    // Reset state
    check("rst_rdata", {120'd0, rdata}, 128'd0);
    check("rst_core_start", {127'd0, core_start}, 128'd0);
    check("rst_core_key", core_key, 128'd0);
    check("rst_core_ptext", core_ptext, 128'd0);
    op_rd(8'h00); op_rd(8'h1F); op_rd(8'h20); op_rd(8'h31); op_rd(8'h32); op_rd(8'h30);

    // FIPS-197 C.1
    for (int i = 0; i < 16; i++) op_wr(8'(i), 8'(i));
    for (int i = 0; i < 16; i++) op_wr(8'(8'h10 + i), 8'(8'h11 * i));
    idle(1);
    check("fips_core_key", core_key, FIPS_KEY);
    check("fips_core_ptext", core_ptext, FIPS_PT);
    lat = 10; s0 = start_cnt;
    op_wr(8'h30, 8'h01);
    idle(2);
    op_rd(8'h31);
    wait_done("fips_done");
    op_rd(8'h31);
    for (int i = 0; i < 16; i++) op_rd(8'(8'h20 + i));
    op_rd(8'h32);
    idle(1);
    check("fips_start_pulses", 128'(start_cnt - s0), 128'd1);

    // KEY write while busy, then CLEAR
    lat = 12;
    op_wr(8'h30, 8'h01);
    idle(2);
    op_wr(8'h05, 8'hAA);
    op_rd(8'h05);
    op_rd(8'h31);
    wait_done("busy_wr_done");
    op_wr(8'h30, 8'h02);
    op_rd(8'h31);
    op_rd(8'h05);

    // Back-to-back START
    lat = 6; s0 = start_cnt;
    op_wr(8'h30, 8'h01);
    op_wr(8'h30, 8'h01);
    idle(2);
    op_rd(8'h31);
    wait_done("b2b_done");
    idle(2);
    check("b2b_start_pulses", 128'(start_cnt - s0), 128'd1);
    op_rd(8'h31);

    // Unmapped and read-only addresses
    op_rd(8'h40); op_rd(8'hFF); op_rd(8'h33);
    op_wr(8'h20, 8'h77); op_wr(8'h31, 8'hFF); op_wr(8'h32, 8'h55);
    op_rd(8'h20); op_rd(8'h31); op_rd(8'h32);

    // Randomized operand loads and runs
    for (int it = 0; it < 12; it++) begin
      for (int j = 0; j < 4; j++) begin
        a = 8'($urandom_range(0, 63));
        if (a == 8'h30) a = 8'h31;
        op_wr(a, 8'($urandom));
      end
      for (int j = 0; j < 3; j++) op_rd(8'($urandom_range(0, 255)));
      lat = $urandom_range(4, 40); s0 = start_cnt;
      op_wr(8'h30, {6'b0, 1'($urandom), 1'b1});
      idle(2);
      if ($urandom_range(0, 1) == 1) op_wr(8'($urandom_range(0, 31)), 8'($urandom));
      else idle(1);
      op_rd(8'h31);
      wait_done("rand_done");
      op_rd(8'h31); op_rd(8'h32); op_rd(8'(8'h20 + $urandom_range(0, 15)));
      idle(1);
      check("rand_start_pulses", 128'(start_cnt - s0), 128'd1);
      if ($urandom_range(0, 1) == 1) op_wr(8'h30, 8'h02);
    end

    // Core that never answers
    op_wr(8'h30, 8'h02);
    lat = 0;
    op_wr(8'h30, 8'h01);
`ifdef AES_REGBANK_WATCHDOG_EN
    idle(62);
    op_rd(8'h31);
    idle(3);
    busy_m = 0; tmo_m = 1; cyc_m = 8'd64;
    op_rd(8'h31);
    op_rd(8'h32);
    op_rd(8'h20);
    lat = 5; s0 = start_cnt;
    op_wr(8'h30, 8'h01);
    idle(2);
    op_rd(8'h31);
    wait_done("wd_restart_done");
    op_rd(8'h31);
    idle(1);
    check("wd_restart_pulses", 128'(start_cnt - s0), 128'd1);
`else
    for (int k = 0; k < 10; k++) begin
      idle(99);
      op_rd(8'h31);
    end
    do_reset(2);
`endif

    // Reset in the middle of a run, core answers late
    lat = 20; s0 = start_cnt;
    op_wr(8'h30, 8'h01);
    idle(5);
    do_reset(2);
    idle(25);
    check("midrst_core_start", {127'd0, core_start}, 128'd0);
    check("midrst_core_key", core_key, 128'd0);
    check("midrst_core_ptext", core_ptext, 128'd0);
    check("midrst_rdata", {120'd0, rdata}, 128'd0);
    check("midrst_start_pulses", 128'(start_cnt - s0), 128'd1);
    op_rd(8'h31); op_rd(8'h20); op_rd(8'h2F); op_rd(8'h32); op_rd(8'h00);

    idle(3);
    check("rdq_drained", 128'(rdq.size()), 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
